// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths, the reservation-station entry record and the
// CDB wakeup helper used by the ALU reservation station.
package alu_rs_pkg;

  localparam int unsigned RsSize = 16;  // entries in the station
  localparam int unsigned RsIdxW = 4;   // RSIndexBus width
  localparam int unsigned TagW   = 5;   // TagBus width
  localparam int unsigned OpW    = 6;   // OPBus width
  localparam int unsigned DataW  = 32;  // DataBus width
  localparam int unsigned AddrW  = 32;  // AddressBus width

  localparam logic [TagW-1:0] TagNull = '0;  // "no producer" tag

  // Payload of one station entry; busy is kept in a separate vector.
  typedef struct packed {
    logic [OpW-1:0]   op;
    logic [DataW-1:0] imm;
    logic [AddrW-1:0] pc;
    logic [TagW-1:0]  dest;
    logic             v1;
    logic [DataW-1:0] d1;
    logic [TagW-1:0]  t1;
    logic             v2;
    logic [DataW-1:0] d2;
    logic [TagW-1:0]  t2;
  } rs_entry_t;

  // Capture any matching CDB broadcast into the waiting operands of an entry.
  // The ALU bus is checked first; the two buses never carry the same tag.
  function automatic rs_entry_t rs_wake(rs_entry_t e,
                                        logic alu_v, logic [TagW-1:0] alu_t,
                                        logic [DataW-1:0] alu_d,
                                        logic lsb_v, logic [TagW-1:0] lsb_t,
                                        logic [DataW-1:0] lsb_d);
    rs_entry_t r;
    r = e;
    if (!e.v1) begin
      if (alu_v && alu_t == e.t1) begin
        r.v1 = 1'b1;
        r.d1 = alu_d;
        r.t1 = TagNull;
      end else if (lsb_v && lsb_t == e.t1) begin
        r.v1 = 1'b1;
        r.d1 = lsb_d;
        r.t1 = TagNull;
      end
    end
    if (!e.v2) begin
      if (alu_v && alu_t == e.t2) begin
        r.v2 = 1'b1;
        r.d2 = alu_d;
        r.t2 = TagNull;
      end else if (lsb_v && lsb_t == e.t2) begin
        r.v2 = 1'b1;
        r.d2 = lsb_d;
        r.t2 = TagNull;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_select.sv
// rs_select: lowest-index priority picker over a request vector.
// Ports:
//   req   - request vector, bit i set when slot i is a candidate
//   grant - one-hot of the lowest-index set request (zero when none)
//   idx   - binary index of that request (zero when none)
//   found - at least one request is set
module rs_select #(
  parameter int unsigned Width = 16,
  parameter int unsigned IdxW  = 4
) (
  input  logic [Width-1:0] req,
  output logic [Width-1:0] grant,
  output logic [IdxW-1:0]  idx,
  output logic             found
);

  // Scan from the top down so the lowest index wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = i[IdxW-1:0];
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: 16-entry reservation station feeding the ALU.
// Allocates dispatched ops into the lowest free entry, wakes waiting operands
// from the ALU and LSB common data buses (including same-cycle bypass at
// allocation) and issues the lowest-index ready entry each cycle.
// Ports:
//   clk_in, rst_n_in (sync, active-low), rdy_in (low freezes), clear_in (flush)
//   ALURS_* - dispatch request and operands
//   CDB_ALU_*, CDB_LSB_* - result broadcasts
//   ALURS_full - registered; high when occupancy after the edge is >= 15
//   ALU_* - registered issue to the ALU; payload holds when ALU_enable is low
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             clear_in,

  input  logic             ALURS_enable,
  input  logic [OpW-1:0]   ALURS_op,
  input  logic [DataW-1:0] ALURS_imm,
  input  logic [AddrW-1:0] ALURS_pc,
  input  logic             ALURS_reg1_valid,
  input  logic             ALURS_reg2_valid,
  input  logic [DataW-1:0] ALURS_reg1_data,
  input  logic [DataW-1:0] ALURS_reg2_data,
  input  logic [TagW-1:0]  ALURS_reg1_tag,
  input  logic [TagW-1:0]  ALURS_reg2_tag,
  input  logic [TagW-1:0]  ALURS_reg_dest_tag,

  input  logic             CDB_ALU_valid,
  input  logic [TagW-1:0]  CDB_ALU_tag,
  input  logic [DataW-1:0] CDB_ALU_data,
  input  logic             CDB_LSB_valid,
  input  logic [TagW-1:0]  CDB_LSB_tag,
  input  logic [DataW-1:0] CDB_LSB_data,

  output logic             ALURS_full,

  output logic             ALU_enable,
  output logic [OpW-1:0]   ALU_op,
  output logic [DataW-1:0] ALU_reg1,
  output logic [DataW-1:0] ALU_reg2,
  output logic [DataW-1:0] ALU_imm,
  output logic [AddrW-1:0] ALU_pc,
  output logic [TagW-1:0]  ALU_reg_dest_tag
);

  localparam logic [RsIdxW:0] FullLevel = 5'd15;

  logic [RsSize-1:0] busy_q, busy_d;
  rs_entry_t         entry_q [RsSize];
  rs_entry_t         entry_d [RsSize];
  logic [RsIdxW:0]   count_q, count_d;

  logic [RsSize-1:0] ready_vec, free_vec;
  logic [RsSize-1:0] ready_grant, free_grant;
  logic [RsIdxW-1:0] ready_idx, free_idx;
  logic              ready_found, free_found;
  logic              issue, alloc;
  rs_entry_t         new_entry;

  always_comb begin
    for (int i = 0; i < RsSize; i++) begin
      ready_vec[i] = busy_q[i] && entry_q[i].v1 && entry_q[i].v2;
    end
    free_vec = ~busy_q;
  end

  rs_select #(.Width(RsSize), .IdxW(RsIdxW)) u_free_sel (
    .req   (free_vec),
    .grant (free_grant),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_select #(.Width(RsSize), .IdxW(RsIdxW)) u_ready_sel (
    .req   (ready_vec),
    .grant (ready_grant),
    .idx   (ready_idx),
    .found (ready_found)
  );

  assign issue = ready_found;
  assign alloc = ALURS_enable && free_found;

  always_comb begin
    new_entry.op   = ALURS_op;
    new_entry.imm  = ALURS_imm;
    new_entry.pc   = ALURS_pc;
    new_entry.dest = ALURS_reg_dest_tag;
    new_entry.v1   = ALURS_reg1_valid;
    new_entry.d1   = ALURS_reg1_data;
    new_entry.t1   = ALURS_reg1_valid ? TagNull : ALURS_reg1_tag;
    new_entry.v2   = ALURS_reg2_valid;
    new_entry.d2   = ALURS_reg2_data;
    new_entry.t2   = ALURS_reg2_valid ? TagNull : ALURS_reg2_tag;
  end

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < RsSize; i++) begin
      entry_d[i] = rs_wake(entry_q[i], CDB_ALU_valid, CDB_ALU_tag, CDB_ALU_data,
                           CDB_LSB_valid, CDB_LSB_tag, CDB_LSB_data);
    end
    // Free set comes from the pre-edge busy vector, so an issuing slot is
    // never reused in the same cycle.
    if (issue) busy_d = busy_d & ~ready_grant;
    if (alloc) begin
      busy_d            = busy_d | free_grant;
      entry_d[free_idx] = rs_wake(new_entry, CDB_ALU_valid, CDB_ALU_tag, CDB_ALU_data,
                                  CDB_LSB_valid, CDB_LSB_tag, CDB_LSB_data);
    end
    count_d = count_q + {{RsIdxW{1'b0}}, alloc} - {{RsIdxW{1'b0}}, issue};
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      busy_q           <= '0;
      count_q          <= '0;
      ALURS_full       <= 1'b0;
      ALU_enable       <= 1'b0;
      ALU_op           <= '0;
      ALU_reg1         <= '0;
      ALU_reg2         <= '0;
      ALU_imm          <= '0;
      ALU_pc           <= '0;
      ALU_reg_dest_tag <= '0;
    end else if (clear_in) begin
      busy_q     <= '0;
      count_q    <= '0;
      ALURS_full <= 1'b0;
      ALU_enable <= 1'b0;
    end else if (rdy_in) begin
      busy_q     <= busy_d;
      count_q    <= count_d;
      ALURS_full <= (count_d >= FullLevel);
      ALU_enable <= issue;
      if (issue) begin
        ALU_op           <= entry_q[ready_idx].op;
        ALU_reg1         <= entry_q[ready_idx].d1;
        ALU_reg2         <= entry_q[ready_idx].d2;
        ALU_imm          <= entry_q[ready_idx].imm;
        ALU_pc           <= entry_q[ready_idx].pc;
        ALU_reg_dest_tag <= entry_q[ready_idx].dest;
      end
    end else begin
      ALU_enable <= 1'b0;
    end
  end

  // Payload is qualified by busy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && !clear_in && rdy_in) begin
      for (int i = 0; i < RsSize; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Dispatch into a full station is dropped; flag it in simulation.
  assert property (@(posedge clk_in) disable iff (!rst_n_in || clear_in || !rdy_in)
                   !(ALURS_enable && !free_found));

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed self-checking bench for alu_rs.
module tb_alu_rs;

  logic        clk_in, rst_n_in, rdy_in, clear_in;
  logic        ALURS_enable;
  logic [5:0]  ALURS_op;
  logic [31:0] ALURS_imm, ALURS_pc;
  logic        ALURS_reg1_valid, ALURS_reg2_valid;
  logic [31:0] ALURS_reg1_data, ALURS_reg2_data;
  logic [4:0]  ALURS_reg1_tag, ALURS_reg2_tag, ALURS_reg_dest_tag;
  logic        CDB_ALU_valid, CDB_LSB_valid;
  logic [4:0]  CDB_ALU_tag, CDB_LSB_tag;
  logic [31:0] CDB_ALU_data, CDB_LSB_data;
  logic        ALURS_full, ALU_enable;
  logic [5:0]  ALU_op;
  logic [31:0] ALU_reg1, ALU_reg2, ALU_imm, ALU_pc;
  logic [4:0]  ALU_reg_dest_tag;

  int n_checks = 0;
  int n_pass   = 0;

  alu_rs dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .rdy_in             (rdy_in),
    .clear_in           (clear_in),
    .ALURS_enable       (ALURS_enable),
    .ALURS_op           (ALURS_op),
    .ALURS_imm          (ALURS_imm),
    .ALURS_pc           (ALURS_pc),
    .ALURS_reg1_valid   (ALURS_reg1_valid),
    .ALURS_reg2_valid   (ALURS_reg2_valid),
    .ALURS_reg1_data    (ALURS_reg1_data),
    .ALURS_reg2_data    (ALURS_reg2_data),
    .ALURS_reg1_tag     (ALURS_reg1_tag),
    .ALURS_reg2_tag     (ALURS_reg2_tag),
    .ALURS_reg_dest_tag (ALURS_reg_dest_tag),
    .CDB_ALU_valid      (CDB_ALU_valid),
    .CDB_ALU_tag        (CDB_ALU_tag),
    .CDB_ALU_data       (CDB_ALU_data),
    .CDB_LSB_valid      (CDB_LSB_valid),
    .CDB_LSB_tag        (CDB_LSB_tag),
    .CDB_LSB_data       (CDB_LSB_data),
    .ALURS_full         (ALURS_full),
    .ALU_enable         (ALU_enable),
    .ALU_op             (ALU_op),
    .ALU_reg1           (ALU_reg1),
    .ALU_reg2           (ALU_reg2),
    .ALU_imm            (ALU_imm),
    .ALU_pc             (ALU_pc),
    .ALU_reg_dest_tag   (ALU_reg_dest_tag)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    ALURS_enable  = 1'b0;
    CDB_ALU_valid = 1'b0;
    CDB_LSB_valid = 1'b0;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic v1, input logic [31:0] d1,
                          input logic [4:0] t1, input logic v2, input logic [31:0] d2,
                          input logic [4:0] t2, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [4:0] dest);
    ALURS_enable       = 1'b1;
    ALURS_op           = op;
    ALURS_reg1_valid   = v1;
    ALURS_reg1_data    = d1;
    ALURS_reg1_tag     = t1;
    ALURS_reg2_valid   = v2;
    ALURS_reg2_data    = d2;
    ALURS_reg2_tag     = t2;
    ALURS_imm          = imm;
    ALURS_pc           = pc;
    ALURS_reg_dest_tag = dest;
  endtask

  task automatic cdb_alu(input logic [4:0] t, input logic [31:0] d);
    CDB_ALU_valid = 1'b1;
    CDB_ALU_tag   = t;
    CDB_ALU_data  = d;
  endtask

  task automatic cdb_lsb(input logic [4:0] t, input logic [31:0] d);
    CDB_LSB_valid = 1'b1;
    CDB_LSB_tag   = t;
    CDB_LSB_data  = d;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    dispatch(6'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    CDB_ALU_tag = '0; CDB_ALU_data = '0; CDB_LSB_tag = '0; CDB_LSB_data = '0;
    idle();
    tick(); tick();
    check("rst_en", {31'd0, ALU_enable}, 32'd0);
    check("rst_full", {31'd0, ALURS_full}, 32'd0);
    check("rst_op", {26'd0, ALU_op}, 32'd0);
    check("rst_reg1", ALU_reg1, 32'd0);
    check("rst_reg2", ALU_reg2, 32'd0);
    check("rst_imm", ALU_imm, 32'd0);
    check("rst_pc", ALU_pc, 32'd0);
    check("rst_dest", {27'd0, ALU_reg_dest_tag}, 32'd0);
    rst_n_in = 1'b1;
    tick();

    // Ready at allocation: issues one edge later.
    dispatch(6'h13, 1'b1, 32'd5, 5'd0, 1'b1, 32'd0, 5'd0, 32'd3, 32'h100, 5'd3);
    tick(); idle();
    check("addi_no_early", {31'd0, ALU_enable}, 32'd0);
    tick();
    check("addi_en", {31'd0, ALU_enable}, 32'd1);
    check("addi_reg1", ALU_reg1, 32'd5);
    check("addi_imm", ALU_imm, 32'd3);
    check("addi_op", {26'd0, ALU_op}, 32'h13);
    check("addi_pc", ALU_pc, 32'h100);
    check("addi_dest", {27'd0, ALU_reg_dest_tag}, 32'd3);
    tick();
    check("addi_en_drop", {31'd0, ALU_enable}, 32'd0);
    check("addi_hold", ALU_reg1, 32'd5);

    // Wakeup on the ALU bus.
    dispatch(6'h01, 1'b0, 32'd0, 5'd7, 1'b1, 32'd2, 5'd0, 32'd0, 32'h104, 5'd4);
    tick(); idle(); tick();
    check("wait_no_issue", {31'd0, ALU_enable}, 32'd0);
    cdb_alu(5'd7, 32'h10);
    tick(); idle();
    check("wake_edge_no_issue", {31'd0, ALU_enable}, 32'd0);
    tick();
    check("wake_en", {31'd0, ALU_enable}, 32'd1);
    check("wake_reg1", ALU_reg1, 32'h10);
    check("wake_reg2", ALU_reg2, 32'd2);
    check("wake_dest", {27'd0, ALU_reg_dest_tag}, 32'd4);

    // Same-cycle bypass from the LSB bus.
    dispatch(6'h02, 1'b1, 32'd1, 5'd0, 1'b0, 32'd0, 5'd9, 32'd0, 32'h108, 5'd5);
    cdb_lsb(5'd9, 32'hAB);
    tick(); idle();
    check("byp_no_early", {31'd0, ALU_enable}, 32'd0);
    tick();
    check("byp_en", {31'd0, ALU_enable}, 32'd1);
    check("byp_reg2", ALU_reg2, 32'hAB);

    // Two entries woken together: lowest index issues first.
    dispatch(6'h03, 1'b0, 32'd0, 5'd30, 1'b1, 32'd0, 5'd0, 32'd0, 32'h10c, 5'd5);
    tick();
    dispatch(6'h03, 1'b0, 32'd0, 5'd31, 1'b1, 32'd0, 5'd0, 32'd0, 32'h110, 5'd6);
    tick(); idle();
    cdb_alu(5'd30, 32'h30);
    cdb_lsb(5'd31, 32'h31);
    tick(); idle();
    check("pri_no_early", {31'd0, ALU_enable}, 32'd0);
    tick();
    check("pri_first_dest", {27'd0, ALU_reg_dest_tag}, 32'd5);
    check("pri_first_reg1", ALU_reg1, 32'h30);
    tick();
    check("pri_second_en", {31'd0, ALU_enable}, 32'd1);
    check("pri_second_dest", {27'd0, ALU_reg_dest_tag}, 32'd6);
    check("pri_second_reg1", ALU_reg1, 32'h31);
    tick();
    check("pri_done", {31'd0, ALU_enable}, 32'd0);

    // Allocate and issue in the same cycle.
    dispatch(6'h04, 1'b1, 32'hA, 5'd0, 1'b1, 32'd0, 5'd0, 32'd0, 32'h114, 5'd7);
    tick();
    dispatch(6'h04, 1'b1, 32'hB, 5'd0, 1'b1, 32'd0, 5'd0, 32'd0, 32'h118, 5'd8);
    tick(); idle();
    check("b2b_first", {27'd0, ALU_reg_dest_tag}, 32'd7);
    tick();
    check("b2b_second_en", {31'd0, ALU_enable}, 32'd1);
    check("b2b_second", ALU_reg1, 32'hB);

    // rdy_in low freezes; a dispatch during the freeze is ignored.
    dispatch(6'h05, 1'b1, 32'hC, 5'd0, 1'b1, 32'd0, 5'd0, 32'd0, 32'h11c, 5'd9);
    tick();
    rdy_in = 1'b0;
    dispatch(6'h05, 1'b1, 32'hD, 5'd0, 1'b1, 32'd0, 5'd0, 32'd0, 32'h120, 5'd10);
    tick(); idle();
    check("frz_en", {31'd0, ALU_enable}, 32'd0);
    check("frz_hold", ALU_reg1, 32'hB);
    rdy_in = 1'b1;
    tick();
    check("frz_resume_en", {31'd0, ALU_enable}, 32'd1);
    check("frz_resume_reg1", ALU_reg1, 32'hC);
    tick();
    check("frz_drop", {31'd0, ALU_enable}, 32'd0);

    // Fill to 15 waiting ops.
    for (int k = 1; k <= 15; k++) begin
      dispatch(6'h06, 1'b0, 32'd0, k[4:0], 1'b1, 32'd0, 5'd0, 32'd0, 32'h200, k[4:0]);
      tick();
      if (k == 14) check("full_at_14", {31'd0, ALURS_full}, 32'd0);
    end
    idle();
    check("full_at_15", {31'd0, ALURS_full}, 32'd1);
    tick();
    check("full_hold", {31'd0, ALURS_full}, 32'd1);
    cdb_alu(5'd1, 32'h55);
    tick(); idle();
    check("full_wake_edge", {31'd0, ALURS_full}, 32'd1);
    tick();
    check("full_issue_en", {31'd0, ALU_enable}, 32'd1);
    check("full_issue_reg1", ALU_reg1, 32'h55);
    check("full_cleared", {31'd0, ALURS_full}, 32'd0);

    // Flush with a concurrent dispatch of a ready op.
    clear_in = 1'b1;
    dispatch(6'h07, 1'b1, 32'hE, 5'd0, 1'b1, 32'd0, 5'd0, 32'd0, 32'h300, 5'd11);
    tick();
    clear_in = 1'b0; idle();
    check("clr_en", {31'd0, ALU_enable}, 32'd0);
    check("clr_full", {31'd0, ALURS_full}, 32'd0);
    tick();
    check("clr_no_discarded_issue", {31'd0, ALU_enable}, 32'd0);
    cdb_alu(5'd2, 32'h66);
    tick(); idle(); tick();
    check("clr_no_stale_wake", {31'd0, ALU_enable}, 32'd0);

    // Reset mid-operation.
    for (int k = 20; k < 25; k++) begin
      dispatch(6'h08, 1'b0, 32'd0, k[4:0], 1'b1, 32'd0, 5'd0, 32'd0, 32'h400, k[4:0]);
      tick();
    end
    idle();
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    check("mid_rst_en", {31'd0, ALU_enable}, 32'd0);
    check("mid_rst_reg1", ALU_reg1, 32'd0);
    check("mid_rst_dest", {27'd0, ALU_reg_dest_tag}, 32'd0);
    check("mid_rst_pc", ALU_pc, 32'd0);
    dispatch(6'h09, 1'b1, 32'hF, 5'd0, 1'b1, 32'd0, 5'd0, 32'd0, 32'h500, 5'd12);
    tick(); idle(); tick();
    check("post_rst_en", {31'd0, ALU_enable}, 32'd1);
    check("post_rst_dest", {27'd0, ALU_reg_dest_tag}, 32'd12);
    cdb_alu(5'd20, 32'h77);
    tick(); idle(); tick();
    check("post_rst_no_stale", {31'd0, ALU_enable}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL provide: clk_in  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL provide: rst_n_in  input  1  reset, synchronous and active-low.
REQ-003 SHALL provide: rdy_in  input  1  global ready; low freezes the block.
REQ-004 SHALL provide: clear_in  input  1  ROB misprediction flush.
REQ-005 SHALL provide dispatch inputs: ALURS_enable 1; ALURS_op `OPBus (6); ALURS_imm `DataBus (32); ALURS_pc `AddressBus (32).
REQ-006 SHALL provide dispatch operand inputs: ALURS_reg1_valid/reg2_valid 1; ALURS_reg1_data/reg2_data 32; ALURS_reg1_tag/reg2_tag `TagBus (5); ALURS_reg_dest_tag 5.
REQ-007 SHALL provide CDB inputs, two buses k=ALU,LSB: CDB_k_valid 1, CDB_k_tag 5, CDB_k_data 32.
REQ-008 SHALL provide: ALURS_full  output  1  registered; tells ID/dispatch to stall.
REQ-009 SHALL provide ALU outputs, all registered: ALU_enable 1; ALU_op 6; ALU_reg1, ALU_reg2, ALU_imm 32; ALU_pc 32; ALU_reg_dest_tag 5.

Function
REQ-010 SHALL hold 16 entries (`RSSize), each: busy, op, imm, pc, dest tag, and per operand valid/data/tag.
REQ-011 Allocation SHALL happen on a cycle with ALURS_enable=1 and rdy_in=1.
  - Target: lowest-index non-busy entry.
  - Fields captured from dispatch ports.
REQ-012 An operand allocated invalid SHALL capture CDB data in the same cycle when a valid CDB bus carries a matching tag (same-cycle bypass).
REQ-013 Wakeup: each cycle, every busy entry with an invalid operand whose tag matches a valid CDB bus SHALL set valid, store data and clear tag to `Null (0).
  - ALU bus checked before LSB bus.
  - Both buses never carry the same tag.
REQ-014 An entry is ready when busy and both operand valid bits are 1.
  - Select: lowest-index ready entry, at most one per cycle.
  - At the edge it is selected, the entry is freed and the ALU_* outputs load its fields with ALU_enable=1.
  - Otherwise ALU_enable=0 and the other ALU_* outputs hold their values.
REQ-015 Latency:
  - An entry allocated ready at edge N SHALL issue at edge N+1.
  - An entry woken by the CDB at edge E SHALL issue no earlier than edge E+1.
REQ-016 Allocate and issue in the same cycle SHALL both proceed.
  - The freed slot is not reused before the next edge.
REQ-017 ALURS_full SHALL be registered high when post-edge occupancy is >= 15, covering dispatch's one-cycle reaction.
REQ-018 Allocation with no free entry SHALL be dropped, state unchanged; a simulation error is flagged.
REQ-019 clear_in=1 at an edge SHALL override everything else:
  - all busy bits cleared
  - ALU_enable=0
  - ALURS_full=0
  - any allocation in that cycle discarded
REQ-020 rdy_in=0 SHALL freeze all state; ALU_enable=0 for that cycle; clear_in and reset still take effect.
REQ-021 Occupancy SHALL be a 5-bit counter: +1 on allocate, -1 on issue, net 0 when both occur; it never wraps past 16 or below 0.

Reset
REQ-022 When rst_n_in=0 at an edge:
  - all busy bits=0 and occupancy=0
  - ALURS_full=0 and ALU_enable=0
  - ALU_op=0, ALU_reg1=0, ALU_reg2=0, ALU_imm=0, ALU_pc=0, ALU_reg_dest_tag=0
REQ-023 Reset SHALL take priority over clear_in and rdy_in; entry payload fields need not reset.

Structure
REQ-024 RSSize, RSIndexBus (3:0), TagBus, OPBus, DataBus, AddressBus and Null SHALL live in shared cpu_define.v.
REQ-025 A single sub-module, rs_select, SHALL serve both free-slot search and ready-entry search.
  - 16-bit request vector in.
  - Lowest-index one-hot/index out, plus a found flag.
  - Instantiated twice.

Verification
REQ-026 Dispatch ADDI, reg1 valid=5, imm=3 at edge 1 -> ALU_enable=1 at edge 2, ALU_reg1=5, ALU_imm=3.
REQ-027 Dispatch with reg1 tag=7 invalid; CDB_ALU tag=7 data=0x10 at edge 4 -> issues at edge 5 with ALU_reg1=0x10.
REQ-028 Dispatch tag=9 operand in the same cycle that CDB_LSB broadcasts tag=9 data=0xAB -> bypass captured; issues next edge with 0xAB.
REQ-029 Dispatch 15 non-ready ops -> ALURS_full=1 after the 15th edge; wake one -> occupancy back to 14, ALURS_full=0.
REQ-030 8 entries busy and clear_in=1 with a concurrent dispatch -> next cycle occupancy=0, ALU_enable=0, no issue of the discarded op.
REQ-031 rst_n_in=0 mid-operation with 5 busy entries -> all outputs 0 after the edge; a following dispatch allocates entry 0.
